// File: rtl/centroid_divider.sv
// Per-cluster centroid update: three lock-step 8-bit restoring dividers that share one
// pixel-count divisor and turn the colour sums into floor(sum/count), saturating at 8'hFF.
module centroid_divider #(
  parameter int E     = 16,
  parameter int T     = 16,
  parameter int ACC_W = $clog2(255 * 4000 * E * T),
  parameter int CNT_W = $clog2(4000 * E * T)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] red_sum,
  input  logic [ACC_W-1:0] green_sum,
  input  logic [ACC_W-1:0] blue_sum,
  input  logic [CNT_W-1:0] count,
  input  logic [23:0]      old_centroid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      centroid,
  output logic             empty,
  output logic [2:0]       ovf
);

  // Wide enough for the sums and for count<<8, plus a guard bit for the compare.
  localparam int W = ((ACC_W > CNT_W + 8) ? ACC_W : CNT_W + 8) + 1;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   rem     [3];
  logic [W-1:0]   rem_nxt [3];
  logic [7:0]     q       [3];
  logic [7:0]     q_nxt   [3];
  logic [W-1:0]   sum_ext [3];
  logic [CNT_W-1:0] div;
  logic [2:0]     sat;
  logic [2:0]     sat_cap;
  logic [2:0]     idx;
  logic [W-1:0]   trial;
  logic [W-1:0]   sat_lim;

  function automatic logic saturates(input logic [W-1:0] sum, input logic [W-1:0] lim);
    return sum >= lim;
  endfunction

  assign sum_ext[0] = W'(red_sum);
  assign sum_ext[1] = W'(green_sum);
  assign sum_ext[2] = W'(blue_sum);
  assign sat_lim    = W'(count) << 8;
  assign trial      = W'(div) << idx;

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      sat_cap[2-c] = saturates(sum_ext[c], sat_lim);
      rem_nxt[c]   = rem[c];
      q_nxt[c]     = q[c];
      if (!sat[2-c] && rem[c] >= trial) begin
        rem_nxt[c]    = rem[c] - trial;
        q_nxt[c][idx] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    case (state)
      IDLE: if (in_valid) state_nxt = (count == '0) ? DONE : DIV;
      DIV:  if (idx == 3'd0) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      centroid <= 24'h0;
      empty    <= 1'b0;
      ovf      <= 3'b000;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        div <= count;
        sat <= sat_cap;
        idx <= 3'd7;
        for (int c = 0; c < 3; c++) begin
          rem[c] <= sum_ext[c];
          q[c]   <= sat_cap[2-c] ? 8'hFF : 8'h00;
        end
        if (count == '0) begin
          centroid <= old_centroid;
          empty    <= 1'b1;
          ovf      <= 3'b000;
        end
      end else if (state == DIV) begin
        for (int c = 0; c < 3; c++) begin
          rem[c] <= rem_nxt[c];
          q[c]   <= q_nxt[c];
        end
        idx <= idx - 3'd1;
        // Last bit resolved this cycle: publish the finished quotients.
        if (idx == 3'd0) begin
          centroid <= {q_nxt[0], q_nxt[1], q_nxt[2]};
          empty    <= 1'b0;
          ovf      <= sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_centroid_divider.sv
// Self-checking bench for centroid_divider: directed cases plus randomized clusters
// compared against a plain-arithmetic division model.
module tb_centroid_divider;

  localparam int ACC_W = 28;
  localparam int CNT_W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] red_sum, green_sum, blue_sum;
  logic [CNT_W-1:0] count;
  logic [23:0]      old_centroid;
  logic             out_valid;
  logic             out_ready;
  logic [23:0]      centroid;
  logic             empty;
  logic [2:0]       ovf;

  int n_checks = 0;
  int n_pass   = 0;

  centroid_divider dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .red_sum(red_sum), .green_sum(green_sum), .blue_sum(blue_sum),
    .count(count), .old_centroid(old_centroid), .out_valid(out_valid),
    .out_ready(out_ready), .centroid(centroid), .empty(empty), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] ref_chan(input longint sum, input longint cnt);
    if (sum >= cnt * 256) return 8'hFF;
    return 8'(sum / cnt);
  endfunction

  // Caller is at a negedge. Waits for in_ready, issues one cluster, checks latency,
  // optionally applies backpressure with a rejected second request, then handshakes.
  task automatic run_txn(input longint r, input longint g, input longint b, input longint cnt,
                         input logic [23:0] old, input int hold, input bit preready);
    logic [23:0] exp_c;
    logic [2:0]  exp_o;
    logic        exp_e;
    int          lat;
    int          guard;
    guard = 0;
    while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
    check("in_ready_before_issue", in_ready, 1);
    exp_e = (cnt == 0);
    if (exp_e) begin
      exp_c = old; exp_o = 3'b000;
    end else begin
      exp_c = {ref_chan(r, cnt), ref_chan(g, cnt), ref_chan(b, cnt)};
      exp_o = {r >= cnt * 256, g >= cnt * 256, b >= cnt * 256};
    end
    in_valid = 1'b1;
    red_sum = ACC_W'(r); green_sum = ACC_W'(g); blue_sum = ACC_W'(b);
    count = CNT_W'(cnt); old_centroid = old;
    out_ready = preready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (!exp_e) check("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
    check("latency", lat, exp_e ? 0 : 8);
    check("centroid", centroid, exp_c);
    check("empty", empty, exp_e);
    check("ovf", ovf, exp_o);
    if (hold > 0) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      red_sum = ~red_sum; green_sum = ~green_sum; blue_sum = ~blue_sum;
      count = count + 1'b1; old_centroid = ~old;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        check("bp_valid", out_valid, 1);
        check("bp_in_ready", in_ready, 0);
        check("bp_centroid", centroid, exp_c);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("valid_drop", out_valid, 0);
    check("ready_back", in_ready, 1);
    check("hold_centroid", centroid, exp_c);
    out_ready = 1'b0;
  endtask

  initial begin
    longint cnt, r, g, b;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    red_sum = '0; green_sum = '0; blue_sum = '0; count = '0; old_centroid = '0;
    repeat (3) @(negedge clk);
    check("in_ready_in_rst", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_centroid", centroid, 0);
    check("rst_empty", empty, 0);
    check("rst_ovf", ovf, 0);

    run_txn(2550, 1000, 0, 10, 24'h000000, 0, 1'b0);
    run_txn(29, 19, 9, 10, 24'hABCDEF, 0, 1'b1);
    run_txn(5, 6, 7, 0, 24'h123456, 0, 1'b1);
    run_txn(100, 200, 300, 7, 24'h000000, 5, 1'b0);
    run_txn(2560, 50, 0, 10, 24'h000000, 0, 1'b1);
    run_txn(255 * 1024000, 1024000 * 256, 1023999, 1024000, 24'h0, 0, 1'b1);
    run_txn(1, 1, 0, 1, 24'h0, 0, 1'b1);

    // Reset during division discards the result.
    in_valid = 1'b1; red_sum = 28'd500; green_sum = 28'd500; blue_sum = 28'd500;
    count = 20'd3; old_centroid = 24'h0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1 check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid, 0);
    end
    run_txn(2550, 1000, 0, 10, 24'h0, 0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0:       cnt = 0;
        1:       cnt = $urandom_range(1, 20);
        default: cnt = $urandom_range(1, 1024000);
      endcase
      r = (cnt == 0) ? longint'($urandom_range(0, 1000)) :
          cnt * $urandom_range(0, 260) + $urandom_range(0, int'(cnt) - 1);
      g = (cnt == 0) ? 0 : cnt * $urandom_range(0, 255) + $urandom_range(0, int'(cnt) - 1);
      b = (cnt == 0) ? 0 : longint'($urandom_range(0, int'(cnt) * 2));
      run_txn(r, g, b, cnt, 24'($urandom), ($urandom_range(0, 3) == 0) ? 2 : 0,
              1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got %0d passed expected all", n_pass);
    $fatal(1);
  end

endmodule

// File: doc/centroid_divider.md
# centroid_divider

Consumes one cluster's reduced colour sums and pixel count from the adder tree and produces the updated 24-bit RGB centroid by sequential division. Sits between the accumulator reduction stage and the centroid register file that is rebroadcast to the engines. One cluster is processed per valid/ready transaction. Three 8-iteration restoring dividers run in lock-step and share one divisor.

## Interface
- E, 16, number of engines feeding the reduction
- T, 16, threads per engine
- ACC_W, clog2(255*4000*E*T) (28 at defaults), width of each per-colour sum
- CNT_W, clog2(4000*E*T) (20 at defaults), width of the pixel count

Ports:
- clk  input  1  single clock, all logic on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  sums/count/old_centroid are valid
- in_ready  output  1  block can accept a transaction
- red_sum  input  ACC_W  red sum for the cluster
- green_sum  input  ACC_W  green sum
- blue_sum  input  ACC_W  blue sum
- count  input  CNT_W  pixels assigned to the cluster
- old_centroid  input  24  previous centroid {R[23:16],G[15:8],B[7:0]}
- out_valid  output  1  result is valid
- out_ready  input  1  downstream accepts the result
- centroid  output  24  new centroid {R[23:16],G[15:8],B[7:0]}
- empty  output  1  count was 0; centroid = old_centroid
- ovf  output  3  per-channel saturation {R,G,B}

## Operation
- States: IDLE, DIV, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch the three sums into remainder registers, count into the divisor register, and old_centroid. Clear the quotients and set the bit index to 7.
  - If count==0, go to DONE with centroid=old_centroid, empty=1, ovf=0.
  - Otherwise go to DIV.
- Saturation check, at capture: for each channel, if sum >= (count<<8), set that ovf bit and force that quotient to 8'hFF; the channel is then skipped in DIV.
- DIV, one bit per cycle for index i=7..0, each non-saturated channel:
  - If rem >= (count<<i): rem -= count<<i and q[i]=1.
  - Otherwise q[i]=0.
- After i=0, go to DONE. Width rule: the compare and subtract are done at ACC_W+1 bits, so the shifted divisor cannot overflow.
- Result is floor(sum/count), truncated with no rounding.
- DONE: out_valid=1. centroid, empty and ovf are stable until out_valid&out_ready; then return to IDLE.
- in_ready=0 in DIV and DONE. in_valid is ignored there and is not queued.
- Reset in any state: next cycle state=IDLE and out_valid=0. Any in-flight result is discarded.

## Timing
- Reset values: in_ready=1 in the first cycle after rst deasserts (0 while rst is high). out_valid=0, centroid=24'h0, empty=0, ovf=3'b000.
- Accept at edge N (nonzero count): DIV occupies cycles N+1..N+8. out_valid=1 from cycle N+9.
- Accept at edge N with count==0: out_valid=1 from cycle N+1.
- Handshake completes at edge M with out_ready=1. out_valid drops at M+1 and in_ready=1 at M+1.
- Minimum issue interval is 10 cycles (2 cycles for empty clusters).
- out_ready may be held high in advance. The output is still valid for at least one cycle.
- Outputs are registered. centroid, empty and ovf hold their last values after the handshake until the next DONE.

## Test plan
- Basic division: red=2550, green=1000, blue=0, count=10, accepted at N -> centroid=24'hFF6400, empty=0, ovf=0, out_valid rises at N+9.
- Truncation: red=29, green=19, blue=9, count=10 -> centroid=24'h020100.
- Empty cluster: count=0, old_centroid=24'h123456 -> centroid=24'h123456, empty=1, out_valid at N+1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with new data -> centroid stable, in_ready=0, new data not captured. Handshake then returns in_ready=1 the next cycle.
- Saturation: red=2560, green=50, blue=0, count=10 -> R=8'hFF, ovf=3'b100, centroid=24'hFF0500.
- Reset mid-DIV: assert rst at N+4 for one cycle -> out_valid stays 0. in_ready=1 after rst deasserts, and a fresh transaction produces the correct result.
